// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 4-digit seven-segment scan path.
// Anode codes are active low; index 0 is the rightmost digit.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [NUM_DIGITS-1:0][3:0] AN_SEL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    typedef enum logic [1:0] {
        SCAN_BLANK,
        SCAN_ON,
        SCAN_OFF
    } scan_state_e;

    typedef enum logic {
        REQ_A,
        REQ_B
    } req_e;

    function automatic logic [3:0] an_for_digit(input logic [1:0] idx, input logic en);
        return en ? AN_SEL[idx] : AN_OFF;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// whichever requester was not granted last. Bit 0 is requester A, bit 1 is B.
module rr_arb2
    import seven_seg_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    req_e r_last_grant;

    always_comb begin
        o_grant = 2'b00;
        if (!i_rst) begin
            case (i_valid)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = (r_last_grant == REQ_B) ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

    // Resetting to B makes the first tie after reset go to A.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= REQ_B;
        end else if (o_grant[0]) begin
            r_last_grant <= REQ_A;
        end else if (o_grant[1]) begin
            r_last_grant <= REQ_B;
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for the 4-digit seven-segment display: owns the digit file,
// arbitrates two writers, and drives anodes with a blanking gap and PWM window.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int TICK_DIV  = 50_000,
    parameter int BLANK_CYC = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_a_valid,
    output logic       o_a_ready,
    input  logic [1:0] i_a_digit,
    input  logic [3:0] i_a_data,
    input  logic       i_b_valid,
    output logic       o_b_ready,
    input  logic [1:0] i_b_digit,
    input  logic [3:0] i_b_data,
    input  logic [3:0] i_dig_en,
    input  logic [2:0] i_bright,
    output logic [3:0] o_an,
    output logic [3:0] o_mux_out,
    output logic       o_frame_tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int STEP  = (TICK_DIV - BLANK_CYC) >> 3;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] STEP_C     = CNT_W'(STEP);

    if (TICK_DIV < BLANK_CYC + 8 || BLANK_CYC < 1) begin : g_param_check
        $error("seven_seg_scan_ctrl: need BLANK_CYC >= 1 and TICK_DIV >= BLANK_CYC + 8");
    end

    logic [1:0]       w_grant;
    logic [3:0]       r_regs [NUM_DIGITS];
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_s;
    logic [2:0]       r_bright_q;
    logic [3:0]       r_en_q;
    logic [3:0]       r_an;
    logic [3:0]       r_mux_out;
    logic             r_frame_tick;
    logic             w_wrap;
    logic [CNT_W-1:0] w_on_last;
    logic [3:0]       w_an_next;
    scan_state_e      r_state;
    scan_state_e      w_state_next;

    rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid ({i_b_valid, i_a_valid}),
        .o_grant (w_grant)
    );

    assign o_a_ready    = w_grant[0];
    assign o_b_ready    = w_grant[1];
    assign o_an         = r_an;
    assign o_mux_out    = r_mux_out;
    assign o_frame_tick = r_frame_tick;

    // NOTE: this tiny file is reset so the display comes up showing 0 on every digit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_grant[0]) begin
            r_regs[i_a_digit] <= i_a_data;
        end else if (w_grant[1]) begin
            r_regs[i_b_digit] <= i_b_data;
        end
    end

    assign w_wrap = (r_cnt == CNT_LAST);

    // Slot parameters are captured at cnt==0 so mid-slot changes never tear a slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_s          <= '0;
            r_frame_tick <= 1'b0;
            r_bright_q   <= '0;
            r_en_q       <= '0;
            r_mux_out    <= '0;
        end else begin
            r_frame_tick <= w_wrap && (r_s == 2'd3);
            if (w_wrap) begin
                r_cnt <= '0;
                r_s   <= r_s + 2'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_cnt == '0) begin
                r_bright_q <= i_bright;
                r_en_q     <= i_dig_en;
                r_mux_out  <= r_regs[r_s];
            end
        end
    end

    assign w_on_last = BLANK_LAST + STEP_C * (CNT_W'(r_bright_q) + CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SCAN_BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_state_next = r_state;
        if (w_wrap) begin
            w_state_next = SCAN_BLANK;
        end else begin
            case (r_state)
                SCAN_BLANK: if (r_cnt == BLANK_LAST) w_state_next = SCAN_ON;
                SCAN_ON:    if (r_cnt == w_on_last)  w_state_next = SCAN_OFF;
                SCAN_OFF:   w_state_next = SCAN_OFF;
                default:    w_state_next = SCAN_BLANK;
            endcase
        end
    end

    always_comb begin
        w_an_next = AN_OFF;
        if (r_state == SCAN_ON) begin
            w_an_next = an_for_digit(r_s, r_en_q[r_s]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_an <= AN_OFF;
        end else begin
            r_an <= w_an_next;
        end
    end

endmodule
